// File: rtl/fetch_queue.sv
// fetch_queue: PC generator with credit-limited instruction fetch and an in-order decode queue.
// Redirects flush the queue and drop responses to requests issued before the redirect.
module fetch_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [DATA_WIDTH-1:0] imem_resp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [ADDR_WIDTH-1:0] pc_out
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, redirect_base;
    logic [CW-1:0] inflight, discard, count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem [DEPTH];
    logic accept, resp_hit, push, pop;

    // Queue slots plus outstanding requests never exceed DEPTH, so a push can never overflow.
    assign imem_req_valid = !rst && !redirect_valid && ({1'b0, count} + {1'b0, inflight} < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign pc_out         = fetch_pc;
    assign redirect_base  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign accept         = imem_req_valid && imem_req_ready;
    assign resp_hit       = !rst && imem_resp_valid && inflight != '0;
    assign out_valid      = !rst && count != '0;
    assign out_instr      = instr_mem[rd_ptr];
    assign out_pc         = pc_mem[rd_ptr];
    assign pop            = out_valid && out_ready && !redirect_valid;
    assign push           = resp_hit && discard == '0 && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base;
            resp_pc  <= redirect_base;
            inflight <= inflight - CW'(resp_hit);
            discard  <= inflight - CW'(resp_hit);
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + STEP;
            inflight <= inflight + CW'(accept) - CW'(resp_hit);
            if (resp_hit && discard != '0)
                discard <= discard - CW'(1);
            if (push) begin
                resp_pc <= resp_pc + STEP;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_resp_data;
            pc_mem[wr_ptr]    <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random checks of fetch_queue against an epoch-tagged request model.
// A second 64-bit instance checks the wider PC step and spurious-response immunity.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, imem_req_valid, imem_req_ready, imem_resp_valid, redirect_valid;
    logic        out_valid, out_ready;
    logic [31:0] imem_req_addr, imem_resp_data, redirect_pc, out_instr, out_pc, pc_out;

    logic        w_rst, w_req_valid, w_req_ready, w_resp_valid, w_redirect_valid, w_out_valid, w_out_ready;
    logic [31:0] w_req_addr, w_redirect_pc, w_out_pc, w_pc_out;
    logic [63:0] w_resp_data, w_out_instr;

    fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .pc_out(pc_out)
    );

    fetch_queue #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut64 (
        .clk(clk), .rst(w_rst),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(w_req_ready),
        .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr), .out_pc(w_out_pc),
        .pc_out(w_pc_out)
    );

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    req_t        pending[$];
    ent_t        expq[$];
    logic [31:0] pops[$];
    int          epoch, n_acc, mem_p, total, bad;
    logic [31:0] model_pc;
    bit          spurious;

    function automatic logic [63:0] mem_word(logic [31:0] a);
        return {a ^ 32'h1357_9bdf, ~a ^ 32'h0f0f_0000};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives memory, checks outputs at the falling edge, then advances the model to the next rising edge.
    task automatic cycle();
        logic        exp_rv, hit, popq, keep, resp;
        logic [63:0] w;
        req_t        r;
        ent_t        e;
        hit = pending.size() > 0 && $urandom_range(99) < mem_p;
        imem_resp_valid = hit || (spurious && pending.size() == 0);
        w = hit ? mem_word(pending[0].addr) : {32'h0, $urandom};
        imem_resp_data = w[31:0];
        @(negedge clk);
        exp_rv = !rst && !redirect_valid && (expq.size() + pending.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("out_valid", out_valid, !rst && expq.size() > 0);
        if (!rst) begin
            chk("pc_out", pc_out, model_pc);
            chk("req_addr", imem_req_addr, model_pc);
        end
        if (!rst && expq.size() > 0) begin
            chk("out_instr", out_instr, expq[0].instr);
            chk("out_pc", out_pc, expq[0].pc);
        end
        if (rst) begin
            pending.delete();
            expq.delete();
            model_pc = 32'h0;
            epoch++;
        end else begin
            popq = !redirect_valid && expq.size() > 0 && out_ready;
            resp = imem_resp_valid && pending.size() > 0;
            keep = 1'b0;
            if (resp) begin
                r = pending.pop_front();
                keep = !redirect_valid && r.epoch == epoch;
            end
            if (redirect_valid) begin
                expq.delete();
                epoch++;
                model_pc = {redirect_pc[31:2], 2'b00};
            end else begin
                if (popq) begin
                    pops.push_back(out_pc);
                    void'(expq.pop_front());
                end
                if (keep) begin
                    w = mem_word(r.addr);
                    e.instr = w[31:0];
                    e.pc = r.addr;
                    expq.push_back(e);
                end
                if (exp_rv && imem_req_ready) begin
                    r.addr = model_pc;
                    r.epoch = epoch;
                    pending.push_back(r);
                    model_pc += 32'd4;
                    n_acc++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        acc, prev_acc;
        logic [31:0] prev_addr, addr;
        int          nseen;
        total = 0; bad = 0; epoch = 0; n_acc = 0; model_pc = 32'h0;
        rst = 1'b1; imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0; mem_p = 100; spurious = 1'b0;
        w_rst = 1'b1; w_req_ready = 1'b0; w_resp_valid = 1'b0; w_resp_data = 64'h0;
        w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_out_ready = 1'b0;
        repeat (2) cycle();
        rst = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1;
        repeat (20) cycle();
        // Decode stalled: exactly DEPTH requests, then fetch resumes at 0x10.
        rst = 1'b1; cycle(); rst = 1'b0;
        out_ready = 1'b0; n_acc = 0;
        repeat (12) cycle();
        chk("stall_accepts", n_acc, 4);
        chk("stall_req_valid", imem_req_valid, 0);
        chk("stall_addr", imem_req_addr, 32'h10);
        out_ready = 1'b1;
        repeat (10) cycle();
        // Redirect with two requests outstanding.
        rst = 1'b1; cycle(); rst = 1'b0;
        mem_p = 0;
        repeat (2) cycle();
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        cycle();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_p = 100; pops.delete();
        repeat (12) cycle();
        chk("redir_first_pc", pops.size() > 0 ? pops[0] : 32'hdead_beef, 32'h100);
        // Redirect coinciding with a response and a pop.
        rst = 1'b1; cycle(); rst = 1'b0;
        out_ready = 1'b0; mem_p = 100;
        repeat (2) cycle();
        mem_p = 0;
        repeat (2) cycle();
        chk("pre_redir_out_valid", out_valid, 1);
        mem_p = 100; out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        cycle();
        redirect_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_pc_out", pc_out, 32'h200);
        pops.delete();
        repeat (12) cycle();
        chk("flush_first_pc", pops.size() > 0 ? pops[0] : 32'hdead_beef, 32'h200);
        // Unaligned target and address wrap.
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        cycle();
        redirect_valid = 1'b0;
        chk("align_pc", pc_out, 32'h100);
        repeat (6) cycle();
        redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
        cycle();
        redirect_valid = 1'b0; pops.delete();
        repeat (10) cycle();
        chk("wrap_pc0", pops.size() > 0 ? pops[0] : 32'hdead_beef, 32'hffff_fffc);
        chk("wrap_pc1", pops.size() > 1 ? pops[1] : 32'hdead_beef, 32'h0);
        repeat (400) begin
            imem_req_ready = 1'($urandom_range(1));
            out_ready = $urandom_range(3) != 0;
            mem_p = $urandom_range(100);
            spurious = $urandom_range(7) == 0;
            redirect_valid = $urandom_range(19) == 0;
            redirect_pc = $urandom;
            rst = $urandom_range(99) == 0;
            cycle();
        end
        rst = 1'b0; redirect_valid = 1'b0; spurious = 1'b0;
        // 64-bit instance: spurious response ignored, then PC steps of 8.
        w_rst = 1'b1;
        @(posedge clk); #1;
        w_rst = 1'b0; w_resp_valid = 1'b1; w_resp_data = 64'h1234;
        @(posedge clk); #1;
        w_resp_valid = 1'b0;
        chk("w64_spurious_out_valid", w_out_valid, 0);
        chk("w64_spurious_pc", w_pc_out, 32'h0);
        w_req_ready = 1'b1; w_out_ready = 1'b1;
        chk("w64_req_valid", w_req_valid, 1);
        prev_acc = 1'b0; prev_addr = 32'h0; nseen = 0;
        repeat (30) begin
            w_resp_valid = prev_acc;
            w_resp_data = mem_word(prev_addr);
            @(negedge clk);
            if (w_out_valid && nseen < 8) begin
                chk("w64_out_pc", w_out_pc, 32'(nseen * 8));
                chk("w64_out_instr", w_out_instr, mem_word(32'(nseen * 8)));
                nseen++;
            end
            acc = w_req_valid && w_req_ready;
            addr = w_req_addr;
            @(posedge clk); #1;
            prev_acc = acc;
            prev_addr = addr;
        end
        chk("w64_outputs_seen", nseen, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
